fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage; producer of the inst {inst, pc} word the decode stage consumes.
//  Issues in-order word reads to instruction memory and buffers responses in a small queue.
//  Presents one instruction per cycle to decode and holds it while decode stalls.
//  Redirects on branch (from execute) or jump (from decode), discarding wrong-path data.
//  Stops fetching at a halt opcode.
// PARAMETERS
//  DEPTH    4     queue entries; also the cap on (outstanding reads + queued entries); power of 2, >=2
//  RESET_PC 0     first fetch address after reset
// PORTS
//  clk            in   1     clock
//  rst            in   1     reset; one clock; reset is asynchronous and active-low
//  imem_req       out  1     read request valid
//  imem_addr      out  addr  word address of the request
//  imem_ready     in   1     memory accepts the request this cycle (imem_req && imem_ready)
//  imem_rvalid    in   1     read data valid; responses return in request order, latency >=1
//  imem_rdata     in   16    instruction word
//  to_inst        out  inst  {inst, pc} presented to decode; 16'h0000 (nop) when !to_valid
//  to_valid       out  1     to_inst holds a real instruction
//  stall          in   1     decode hazard hold; head entry is not consumed
//  do_branch      in   1     taken branch from execute; highest priority redirect
//  branch_target  in   addr  target for do_branch
//  do_jump        in   1     jump from decode
//  jump_address   in   addr  target for do_jump
//  halted         out  1     fetch stopped after a halt and the queue is drained
// BEHAVIOUR
//  Reset: pc=RESET_PC, queue empty, outstanding=0, discard=0, state=RUN.
//   Outputs: imem_req=0, to_valid=0, to_inst=0, halted=0.
//  Request: imem_req=1 in RUN when outstanding+count < DEPTH; imem_addr=pc.
//   pc+=1 on accept. pc wraps modulo 2^addr width.
//  Response: accepted rvalid with discard==0 is written to the queue with pc=resp_pc.
//   resp_pc+=1 on each non-discarded response.
//  Latency: rvalid in cycle N -> to_valid in N+1 (queue head drives to_inst combinationally).
//  Consume: the head pops when to_valid && !stall. stall holds to_inst stable.
//  Redirect: do_branch, otherwise do_jump.
//   Next cycle: queue flushed, pc=resp_pc=target, discard=outstanding+accept-rvalid,
//    state=RUN. Same-cycle rvalid is dropped.
//   Redirect beats stall and beats halt detection in the same cycle.
//   The redirect cycle issues no request.
//  Discard: while discard>0, each rvalid decrements discard and is dropped; requests continue.
//  Halt detect: a response with op[15:12]==4'b1111 is queued normally. RUN->DRAIN: no new requests.
//   Younger in-flight responses are discarded.
//   DRAIN->HALTED once the halt entry has been consumed; halted=1, to_valid=0.
//   Any redirect in DRAIN or HALTED returns to RUN (halt was wrong-path); only rst otherwise leaves HALTED.
//  Full: push and pop in the same cycle are both allowed when full. The credit rule prevents overflow.
//   An rvalid with no credit outstanding is a protocol error (assertion).
//  Reset mid-operation: all state clears asynchronously. Responses to pre-reset requests must not arrive.
// CONFIGURATION
//  FETCH_BYPASS_EN defined: when the queue is empty, rvalid is accepted and discard==0, imem_rdata is
//   presented on to_inst the same cycle (to_valid=1), giving 0-cycle added latency.
//   If not stalled, it is not written to the queue; if stalled, it is queued.
//   Without: always via queue, 1-cycle latency.
// STRUCTURE
//  Shared package: addr/block/inst typedefs, OP_HALT=4'b1111, OP_NOP=4'b0000, opcode field bounds.
//  Sub-module fetch_queue: DEPTH-entry sync FIFO of inst with push/pop/flush, count, head output.
//  FSM {RUN, DRAIN, HALTED} plus the outstanding and discard counters live in fetch_unit.
// TESTING
//  Straight line: RESET_PC=0, mem latency 1, no stall -> to_inst.pc 0,1,2,3 on consecutive cycles.
//  Stall: hold stall 3 cycles while pc=5 at head -> to_inst stays pc 5. imem_req drops once
//   outstanding+count==4. Release stall -> pc 6 follows.
//  Branch flush: latency 3, do_branch target 0x20 with 2 reads in flight -> both dropped.
//   Next to_valid shows pc 0x20.
//  Branch+jump same cycle: do_branch->0x40, do_jump->0x80 -> fetch resumes at 0x40.
//  Halt: word 0xF000 at pc 7 -> no request for pc>=9 after detection; pc 8 is discarded.
//   halted=1 after pc 7 is consumed. do_jump to 0x10 -> RUN, fetch 0x10.
//  Async reset asserted mid-stream with a full queue -> to_valid=0, imem_req=0 immediately.
//   Fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   addr_t  : instruction word address
//   block_t : raw 16-bit instruction word as returned by instruction memory
//   inst_t  : {inst, pc} word handed to decode
//   fetch_state_e : fetch control states
package fetch_unit_pkg;

    localparam int ADDR_W = 16;
    localparam int INST_W = 16;

    // Opcode field of an instruction word
    localparam int OP_HI = 15;
    localparam int OP_LO = 12;

    localparam logic [3:0] OP_HALT = 4'b1111;
    localparam logic [3:0] OP_NOP  = 4'b0000;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [INST_W-1:0] block_t;

    typedef struct packed {
        block_t inst;
        addr_t  pc;
    } inst_t;

    // Value driven to decode when nothing valid is presented
    localparam inst_t NOP_INST = '{inst: {OP_NOP, 12'h000}, pc: 16'h0000};

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_DRAIN  = 2'b01,
        ST_HALTED = 2'b10
    } fetch_state_e;

    function automatic logic is_halt(input block_t word);
        return (word[OP_HI:OP_LO] == OP_HALT);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO buffering fetched instructions for decode.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   flush           empties the queue (wins over push/pop)
//   push, push_data write one entry
//   pop             remove the head entry
//   head            current head entry (combinational)
//   count           number of valid entries (0..DEPTH)
// Push and pop in the same cycle are both honoured, also when full.
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  inst_t                  push_data,
    input  logic                   pop,
    output inst_t                  head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    inst_t             mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              do_push_s, do_pop_s;

    // Pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        do_pop_s  = pop && (count_q != '0);
        do_push_s = push && ((count_q != (PTR_W+1)'(DEPTH)) || do_pop_s);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Queue control registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are meaningless while count says empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push_s && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_unit_checker.sv
// Protocol checks for fetch_unit.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   imem_rvalid  memory response valid
//   outstanding  requests accepted but not yet answered
//   count        queue occupancy
module fetch_unit_checker #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input logic             clk,
    input logic             rst,
    input logic             imem_rvalid,
    input logic [CNT_W-1:0] outstanding,
    input logic [CNT_W-1:0] count
);

    // A response may only return against a request still in flight.
    rvalid_has_credit: assert property (@(posedge clk) disable iff (!rst)
        imem_rvalid |-> (outstanding != '0));

    // Reads in flight plus buffered entries never exceed the queue size.
    credit_bound: assert property (@(posedge clk) disable iff (!rst)
        (({1'b0, outstanding} + {1'b0, count}) <= (CNT_W+1)'(DEPTH)));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage.
// Issues in-order word reads, buffers responses, presents one {inst, pc}
// per cycle to decode, redirects on branch/jump and stops at a halt opcode.
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   imem_req/imem_addr/imem_ready  read request handshake
//   imem_rvalid/imem_rdata         in-order read responses
//   to_inst/to_valid               instruction presented to decode
//   stall                          decode holds the presented instruction
//   do_branch/branch_target        execute redirect (highest priority)
//   do_jump/jump_address           decode redirect
//   halted                         halt consumed, fetch stopped
// Build option: FETCH_BYPASS_EN presents a response in the cycle it
// arrives when the queue is empty.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int    DEPTH    = 4,
    parameter addr_t RESET_PC = 16'h0000
) (
    input  logic   clk,
    input  logic   rst,
    output logic   imem_req,
    output addr_t  imem_addr,
    input  logic   imem_ready,
    input  logic   imem_rvalid,
    input  block_t imem_rdata,
    output inst_t  to_inst,
    output logic   to_valid,
    input  logic   stall,
    input  logic   do_branch,
    input  addr_t  branch_target,
    input  logic   do_jump,
    input  addr_t  jump_address,
    output logic   halted
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e     state_q, state_d;
    addr_t            pc_q, pc_d;
    addr_t            resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic             run_en_q, run_en_d;

    logic [CNT_W-1:0] q_count_s;
    inst_t            q_head_s;
    logic             q_push_s, q_pop_s;
    inst_t            resp_inst_s;
    inst_t            pres_s;
    logic             redirect_s;
    addr_t            target_s;
    logic [CNT_W:0]   inflight_s;
    logic             accept_s;
    logic             resp_keep_s;
    logic             head_valid_s;
    logic             bypass_s;
    logic             pres_valid_s;
    logic             consume_s;
    logic             halt_resp_s;
    logic             halt_pop_s;

    // Redirect selection: a taken branch outranks a decode jump.
    always_comb begin
        redirect_s = do_branch || do_jump;
        if (do_branch) begin
            target_s = branch_target;
        end else begin
            target_s = jump_address;
        end
    end

    // Request issue, response acceptance and presentation to decode.
    always_comb begin
        // run_en_q keeps the request low while in reset and for the first cycle after it
        inflight_s   = {1'b0, outstanding_q} + {1'b0, q_count_s};
        imem_req     = run_en_q && (state_q == ST_RUN) && !redirect_s &&
                       (inflight_s < (CNT_W+1)'(DEPTH));
        imem_addr    = pc_q;
        accept_s     = imem_req && imem_ready;
        resp_keep_s  = imem_rvalid && (discard_q == '0);
        resp_inst_s  = '{inst: imem_rdata, pc: resp_pc_q};
        head_valid_s = (q_count_s != '0) && (state_q != ST_HALTED);
`ifdef FETCH_BYPASS_EN
        bypass_s     = (q_count_s == '0) && resp_keep_s && (state_q != ST_HALTED);
`else
        bypass_s     = 1'b0;
`endif
        pres_valid_s = head_valid_s || bypass_s;
        if (head_valid_s) begin
            pres_s = q_head_s;
        end else if (bypass_s) begin
            pres_s = resp_inst_s;
        end else begin
            pres_s = NOP_INST;
        end
        consume_s    = pres_valid_s && !stall && !redirect_s;
        q_pop_s      = consume_s && head_valid_s;
        // A bypassed word consumed on arrival never enters the queue
        q_push_s     = resp_keep_s && !redirect_s && !(bypass_s && !stall);
        halt_resp_s  = resp_keep_s && !redirect_s && is_halt(imem_rdata);
        halt_pop_s   = consume_s && is_halt(pres_s.inst);
        to_inst      = pres_s;
        to_valid     = pres_valid_s;
        halted       = (state_q == ST_HALTED);
    end

    // Next-state logic for the fetch FSM, addresses and credit counters.
    always_comb begin
        run_en_d      = 1'b1;
        outstanding_d = outstanding_q + CNT_W'(accept_s) - CNT_W'(imem_rvalid);
        pc_d          = pc_q;
        resp_pc_d     = resp_pc_q;
        discard_d     = discard_q;
        state_d       = state_q;

        if (accept_s) begin
            pc_d = pc_q + 16'h0001;
        end else begin
            pc_d = pc_q;
        end

        if (resp_keep_s) begin
            resp_pc_d = resp_pc_q + 16'h0001;
        end else begin
            resp_pc_d = resp_pc_q;
        end

        if (imem_rvalid && (discard_q != '0)) begin
            discard_d = discard_q - CNT_W'(1);
        end else begin
            discard_d = discard_q;
        end

        case (state_q)
            ST_RUN: begin
                if (halt_resp_s) begin
                    state_d = halt_pop_s ? ST_HALTED : ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (halt_pop_s) begin
                    state_d = ST_HALTED;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase

        // Everything still in flight is wrong-path after a redirect or a halt
        if (redirect_s) begin
            pc_d      = target_s;
            resp_pc_d = target_s;
            discard_d = outstanding_d;
            state_d   = ST_RUN;
        end else if (halt_resp_s) begin
            discard_d = outstanding_d;
        end else begin
            discard_d = discard_d;
        end
    end

    // Fetch control registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            run_en_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            run_en_q      <= run_en_d;
        end
    end

    fetch_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_s),
        .push      (q_push_s),
        .push_data (resp_inst_s),
        .pop       (q_pop_s),
        .head      (q_head_s),
        .count     (q_count_s)
    );

    fetch_unit_checker #(
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) u_checker (
        .clk         (clk),
        .rst         (rst),
        .imem_rvalid (imem_rvalid),
        .outstanding (outstanding_q),
        .count       (q_count_s)
    );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic   clk, rst, imem_req, imem_ready, imem_rvalid, to_valid;
    logic   stall, do_branch, do_jump, halted;
    addr_t  imem_addr, branch_target, jump_address;
    block_t imem_rdata;
    inst_t  to_inst;

    int     pass_cnt, chk_cnt, cyc, lat, expc, bad_req;
    logic   halt_on, ready_r;
    addr_t  halt_addr;
    addr_t  pend_addr[$];
    int     pend_due[$];
    logic   obs_req, obs_valid, obs_halted;
    addr_t  obs_addr;
    inst_t  obs_inst;

    fetch_unit #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .to_inst(to_inst), .to_valid(to_valid), .stall(stall),
        .do_branch(do_branch), .branch_target(branch_target),
        .do_jump(do_jump), .jump_address(jump_address), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic block_t mem_word(input addr_t a);
        if (halt_on && a == halt_addr) return 16'hF000;
        return {4'h1, a[11:0]};
    endfunction

    // One clock cycle: memory model drives responses, outputs sampled mid-cycle.
    task automatic step();
        if (rst && pend_due.size() > 0 && pend_due[0] == cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 16'h0000;
        end
        imem_ready = ready_r;
        #1;
        obs_req = imem_req; obs_addr = imem_addr; obs_valid = to_valid;
        obs_inst = to_inst; obs_halted = halted;
        if (rst && imem_req && imem_ready) begin
            pend_addr.push_back(imem_addr);
            pend_due.push_back(cyc + lat);
        end
        @(posedge clk); cyc++; @(negedge clk);
    endtask

    task automatic wait_valid();
        step();
        for (int i = 0; i < 40 && !obs_valid; i++) step();
    endtask

    task automatic check_pc(input string name, input addr_t pc);
        chk_cnt++;
        if (obs_valid !== 1'b1 || obs_inst.pc !== pc || obs_inst.inst !== mem_word(pc))
            $display("FAIL %s: got valid=%0b pc=%h inst=%h, expected valid=1 pc=%h inst=%h",
                     name, obs_valid, obs_inst.pc, obs_inst.inst, pc, mem_word(pc));
        else pass_cnt++;
    endtask

    task automatic do_reset();
        rst = 1'b0; stall = 1'b0; do_branch = 1'b0; do_jump = 1'b0; imem_rvalid = 1'b0;
        pend_addr.delete(); pend_due.delete();
        step(); step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        chk_cnt++; if (obs_req !== 1'b0) $display("FAIL reset_req: got %0b expected 0", obs_req); else pass_cnt++;
        chk_cnt++; if (obs_valid !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", obs_valid); else pass_cnt++;
        chk_cnt++; if (obs_inst !== 32'h0) $display("FAIL reset_inst: got %h expected 0", obs_inst); else pass_cnt++;
        chk_cnt++; if (obs_halted !== 1'b0) $display("FAIL reset_halted: got %0b expected 0", obs_halted); else pass_cnt++;
        step();
        rst = 1'b1;
    endtask

    task automatic test_straight();
        wait_valid();
        for (int k = 0; k < 4; k++) begin
            check_pc("straight", addr_t'(k));
            step();
        end
    endtask

    task automatic test_stall();
        check_pc("stall_pre", 16'h0004);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_pc("stall_hold", 16'h0005);
        end
        chk_cnt++; if (obs_req !== 1'b0) $display("FAIL stall_credit: got req=%0b expected 0", obs_req); else pass_cnt++;
        stall = 1'b0;
        step(); check_pc("stall_release", 16'h0005);
        step(); check_pc("stall_next", 16'h0006);
    endtask

    task automatic test_ready_gap();
        expc = 7;
        ready_r = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_cnt++; if (obs_req !== 1'b1) $display("FAIL ready_gap_req: got %0b expected 1", obs_req); else pass_cnt++;
            if (obs_valid) begin check_pc("ready_gap", addr_t'(expc)); expc++; end
        end
        ready_r = 1'b1;
        for (int i = 0; i < 30 && expc < 14; i++) begin
            step();
            if (obs_valid) begin check_pc("ready_resume", addr_t'(expc)); expc++; end
        end
        chk_cnt++; if (expc != 14) $display("FAIL ready_count: got %0d expected 14", expc); else pass_cnt++;
    endtask

    task automatic test_branch_flush();
        int n;
        do_reset();
        lat = 3;
        n = 0;
        for (int i = 0; i < 10 && n < 2; i++) begin
            step();
            if (obs_req && ready_r) n++;
        end
        do_branch = 1'b1; branch_target = 16'h0020;
        step();
        do_branch = 1'b0;
        chk_cnt++; if (obs_req !== 1'b0) $display("FAIL branch_noreq: got %0b expected 0", obs_req); else pass_cnt++;
        wait_valid(); check_pc("branch_first", 16'h0020);
        wait_valid(); check_pc("branch_second", 16'h0021);
    endtask

    task automatic test_branch_jump();
        do_branch = 1'b1; branch_target = 16'h0040;
        do_jump = 1'b1; jump_address = 16'h0080;
        step();
        do_branch = 1'b0; do_jump = 1'b0;
        wait_valid(); check_pc("brjmp_first", 16'h0040);
        wait_valid(); check_pc("brjmp_second", 16'h0041);
    endtask

    task automatic test_halt();
        do_reset();
        lat = 1; halt_on = 1'b1; halt_addr = 16'h0007;
        expc = 0; bad_req = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (obs_req && obs_addr >= 16'h0009) bad_req++;
            if (obs_valid) begin check_pc("halt_seq", addr_t'(expc)); expc++; end
        end
        chk_cnt++; if (expc != 8) $display("FAIL halt_last: got %0d entries expected 8", expc); else pass_cnt++;
        chk_cnt++; if (bad_req != 0) $display("FAIL halt_noreq: got %0d requests expected 0", bad_req); else pass_cnt++;
        chk_cnt++; if (obs_halted !== 1'b1) $display("FAIL halt_flag: got %0b expected 1", obs_halted); else pass_cnt++;
        chk_cnt++; if (obs_valid !== 1'b0) $display("FAIL halt_valid: got %0b expected 0", obs_valid); else pass_cnt++;
        do_jump = 1'b1; jump_address = 16'h0010;
        step();
        do_jump = 1'b0;
        wait_valid(); check_pc("halt_jump", 16'h0010);
        chk_cnt++; if (obs_halted !== 1'b0) $display("FAIL halt_exit: got %0b expected 0", obs_halted); else pass_cnt++;
        halt_on = 1'b0;
    endtask

    task automatic test_async_reset();
        stall = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check_pc("full_head", 16'h0011);
        chk_cnt++; if (obs_req !== 1'b0) $display("FAIL full_req: got %0b expected 0", obs_req); else pass_cnt++;
        #2;
        rst = 1'b0;
        #1;
        chk_cnt++; if (to_valid !== 1'b0) $display("FAIL arst_valid: got %0b expected 0", to_valid); else pass_cnt++;
        chk_cnt++; if (imem_req !== 1'b0) $display("FAIL arst_req: got %0b expected 0", imem_req); else pass_cnt++;
        chk_cnt++; if (to_inst !== 32'h0) $display("FAIL arst_inst: got %h expected 0", to_inst); else pass_cnt++;
        pend_addr.delete(); pend_due.delete();
        imem_rvalid = 1'b0; stall = 1'b0;
        @(posedge clk); cyc++; @(negedge clk);
        step();
        rst = 1'b1;
        wait_valid(); check_pc("arst_restart", 16'h0000);
    endtask

    initial begin
        pass_cnt = 0; chk_cnt = 0; cyc = 0; lat = 1;
        halt_on = 1'b0; halt_addr = 16'h0000; ready_r = 1'b1;
        rst = 1'b0; stall = 1'b0; do_branch = 1'b0; do_jump = 1'b0;
        branch_target = 16'h0000; jump_address = 16'h0000;
        imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 16'h0000;
        @(negedge clk);
        test_reset();
        test_straight();
        test_stall();
        test_ready_gap();
        test_branch_flush();
        test_branch_jump();
        test_halt();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
